// File: rtl/keyboard_spi_rx.sv
// SPI-slave receiver for the keyboard link: synchronizes the raw pins into clk_cpu
// and assembles fixed-length MSB-first frames into a key code register.
module keyboard_spi_rx #(
   parameter int FRAME_BITS     = 16,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                  clk_cpu,
   input  logic                  rst_n,
   input  logic                  key_sck,
   input  logic                  key_mosi,
   input  logic                  key_cs_n,
   output logic [FRAME_BITS-1:0] key_code,
   output logic                  key_strobe,
   output logic                  frame_err,
   output logic                  busy
);

   localparam int CNT_W = $clog2(FRAME_BITS + 2);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_ABORT = 2'd2;

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_OVF  = CNT_W'(FRAME_BITS + 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sck_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic                   r_sck_prev;
   logic                   r_cs_prev;
   logic [SYNC_STAGES:0]   r_settle;
   logic                   r_armed;

   logic [1:0]             r_state;
   logic [FRAME_BITS-1:0]  r_shift;
   logic [CNT_W-1:0]       r_cnt;
   logic [TO_W-1:0]        r_to;
   logic [FRAME_BITS-1:0]  r_key_code;
   logic                   r_strobe;
   logic                   r_err;
   logic                   r_busy;

   logic                   w_sck;
   logic                   w_mosi;
   logic                   w_cs_n;
   logic                   w_sck_rise;
   logic                   w_cs_fall;
   logic                   w_cs_rise;
   logic [FRAME_BITS-1:0]  w_shift_next;
   logic [CNT_W-1:0]       w_cnt_next;
   logic                   w_timeout;
   logic [1:0]             w_state_next;

   // cs_n stages preset high and sck/mosi low so reset release never fakes an edge.
   always_ff @(posedge clk_cpu or negedge rst_n) begin
      if (!rst_n) begin
         r_sck_sync  <= '0;
         r_mosi_sync <= '0;
         r_cs_sync   <= '1;
         r_sck_prev  <= 1'b0;
         r_cs_prev   <= 1'b1;
      end else begin
         r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], key_sck};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], key_mosi};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], key_cs_n};
         r_sck_prev  <= w_sck;
         r_cs_prev   <= w_cs_n;
      end
   end

   assign w_sck  = r_sck_sync[SYNC_STAGES-1];
   assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
   assign w_cs_n = r_cs_sync[SYNC_STAGES-1];

   // A frame may only start once cs_n has been seen genuinely high after reset,
   // so a frame already in flight when reset releases is dropped silently.
   always_ff @(posedge clk_cpu or negedge rst_n) begin
      if (!rst_n) begin
         r_settle <= '0;
         r_armed  <= 1'b0;
      end else begin
         r_settle <= {r_settle[SYNC_STAGES-1:0], 1'b1};
         r_armed  <= r_armed | (r_settle[SYNC_STAGES] & w_cs_n);
      end
   end

   assign w_sck_rise = w_sck & ~r_sck_prev;
   assign w_cs_fall  = r_armed & r_cs_prev & ~w_cs_n;
   assign w_cs_rise  = w_cs_n & ~r_cs_prev;

   // Bit shifted in this cycle is folded in before the frame length is judged.
   assign w_shift_next = w_sck_rise ? {r_shift[FRAME_BITS-2:0], w_mosi} : r_shift;
   assign w_cnt_next   = (w_sck_rise && (r_cnt != CNT_OVF)) ? r_cnt + 1'b1 : r_cnt;
   assign w_timeout    = !w_sck_rise && (r_to == TO_LAST);

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_cs_fall) w_state_next = S_SHIFT;
         end
         S_SHIFT: begin
            if (w_cs_rise)      w_state_next = S_IDLE;
            else if (w_timeout) w_state_next = S_ABORT;
         end
         S_ABORT: begin
            if (w_cs_rise) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_cpu or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_shift    <= '0;
         r_cnt      <= '0;
         r_to       <= '0;
         r_key_code <= '0;
         r_strobe   <= 1'b0;
         r_err      <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_busy   <= (w_state_next == S_SHIFT);
         r_strobe <= 1'b0;
         r_err    <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_cs_fall) begin
                  r_shift <= '0;
                  r_cnt   <= '0;
                  r_to    <= '0;
               end
            end
            S_SHIFT: begin
               r_shift <= w_shift_next;
               r_cnt   <= w_cnt_next;
               r_to    <= w_sck_rise ? '0 : r_to + 1'b1;
               if (w_cs_rise) begin
                  if (w_cnt_next == CNT_FULL) begin
                     r_key_code <= w_shift_next;
                     r_strobe   <= 1'b1;
                  end else begin
                     r_err <= 1'b1;
                  end
               end else if (w_timeout) begin
                  r_err <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign key_code   = r_key_code;
   assign key_strobe = r_strobe;
   assign frame_err  = r_err;
   assign busy       = r_busy;

endmodule

// File: tb/tb_keyboard_spi_rx.sv
// Directed bench for keyboard_spi_rx: frames, length errors, timeout, edge coincidence, reset.
module tb_keyboard_spi_rx;

   localparam int TIMEOUT_CYCLES = 65535;
   localparam int HALF = 10;

   logic        clk_cpu;
   logic        rst_n;
   logic        key_sck;
   logic        key_mosi;
   logic        key_cs_n;
   logic [15:0] key_code;
   logic        key_strobe;
   logic        frame_err;
   logic        busy;

   int total;
   int bad;
   int strobe_cnt;
   int err_cnt;
   int overlap_cnt;

   keyboard_spi_rx #(
      .FRAME_BITS     (16),
      .SYNC_STAGES    (2),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk_cpu    (clk_cpu),
      .rst_n      (rst_n),
      .key_sck    (key_sck),
      .key_mosi   (key_mosi),
      .key_cs_n   (key_cs_n),
      .key_code   (key_code),
      .key_strobe (key_strobe),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   // clock / reset
   initial clk_cpu = 1'b0;
   always #5 clk_cpu = ~clk_cpu;

   // pulse monitor, sampled on the falling edge
   always @(negedge clk_cpu) begin
      if (key_strobe === 1'b1) strobe_cnt++;
      if (frame_err === 1'b1) err_cnt++;
      if (key_strobe === 1'b1 && frame_err === 1'b1) overlap_cnt++;
   end

   // driver tasks
   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk_cpu);
      #1;
   endtask

   task automatic send_bits(input logic [31:0] data, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         key_mosi = data[i];
         wait_cycles(HALF);
         key_sck = 1'b1;
         wait_cycles(HALF);
         key_sck = 1'b0;
      end
   endtask

   task automatic send_frame(input logic [31:0] data, input int n);
      key_cs_n = 1'b0;
      wait_cycles(HALF);
      send_bits(data, n);
      wait_cycles(HALF);
      key_cs_n = 1'b1;
      wait_cycles(HALF);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #1;
      total++;
      if (key_code !== 16'h0000) begin bad++; $display("FAIL reset_code got=%h exp=%h", key_code, 16'h0000); end
      total++;
      if ({key_strobe, frame_err, busy} !== 3'b000) begin
         bad++; $display("FAIL reset_flags got=%b exp=%b", {key_strobe, frame_err, busy}, 3'b000);
      end
      wait_cycles(3);
      rst_n = 1'b1;
      wait_cycles(HALF);
      total++;
      if ({strobe_cnt, err_cnt} !== {32'd0, 32'd0}) begin
         bad++; $display("FAIL reset_pulses got=%0d/%0d exp=0/0", strobe_cnt, err_cnt);
      end
   endtask

   task automatic test_valid;
      int s0, e0;
      s0 = strobe_cnt; e0 = err_cnt;
      key_cs_n = 1'b0;
      wait_cycles(HALF);
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL valid_busy got=%b exp=1", busy); end
      send_bits(32'h0080, 16);
      wait_cycles(HALF);
      key_cs_n = 1'b1;
      repeat (2) @(posedge clk_cpu);
      #1;
      total++;
      if (key_strobe !== 1'b0) begin bad++; $display("FAIL valid_early_strobe got=%b exp=0", key_strobe); end
      @(posedge clk_cpu);
      #1;
      total++;
      if (key_strobe !== 1'b1) begin bad++; $display("FAIL valid_strobe_lat got=%b exp=1", key_strobe); end
      total++;
      if (key_code !== 16'h0080) begin bad++; $display("FAIL valid_code got=%h exp=%h", key_code, 16'h0080); end
      @(posedge clk_cpu);
      #1;
      total++;
      if (key_strobe !== 1'b0) begin bad++; $display("FAIL valid_strobe_width got=%b exp=0", key_strobe); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL valid_busy_end got=%b exp=0", busy); end
      wait_cycles(HALF);
      total++;
      if (strobe_cnt - s0 !== 1 || err_cnt - e0 !== 0) begin
         bad++; $display("FAIL valid_pulses got=%0d/%0d exp=1/0", strobe_cnt - s0, err_cnt - e0);
      end
   endtask

   task automatic test_length;
      logic [31:0] pats [3];
      int          lens [3];
      int s0, e0;
      pats[0] = 32'h0000_7FFF; lens[0] = 15;
      pats[1] = 32'h0001_2345; lens[1] = 17;
      pats[2] = 32'h0000_0000; lens[2] = 0;
      for (int k = 0; k < 3; k++) begin
         s0 = strobe_cnt; e0 = err_cnt;
         send_frame(pats[k], lens[k]);
         total++;
         if (err_cnt - e0 !== 1 || strobe_cnt - s0 !== 0) begin
            bad++; $display("FAIL length_%0d_pulses err=%0d strobe=%0d exp=1/0", lens[k], err_cnt - e0, strobe_cnt - s0);
         end
         total++;
         if (key_code !== 16'h0080) begin bad++; $display("FAIL length_%0d_code got=%h exp=%h", lens[k], key_code, 16'h0080); end
      end
   endtask

   task automatic test_release;
      int s0, e0;
      for (int k = 0; k < 2; k++) begin
         s0 = strobe_cnt; e0 = err_cnt;
         send_frame(32'h0000, 16);
         total++;
         if (key_code !== 16'h0000) begin bad++; $display("FAIL release_%0d_code got=%h exp=%h", k, key_code, 16'h0000); end
         total++;
         if (strobe_cnt - s0 !== 1 || err_cnt - e0 !== 0) begin
            bad++; $display("FAIL release_%0d_pulses got=%0d/%0d exp=1/0", k, strobe_cnt - s0, err_cnt - e0);
         end
      end
   endtask

   task automatic test_timeout;
      int s0, e0, hit;
      s0 = strobe_cnt; e0 = err_cnt; hit = -1;
      key_cs_n = 1'b0;
      wait_cycles(HALF);
      send_bits(32'h15, 5);
      for (int i = 1; i <= TIMEOUT_CYCLES + 10; i++) begin
         @(posedge clk_cpu);
         #1;
         if (frame_err === 1'b1 && hit < 0) hit = i;
      end
      total++;
      if (hit < TIMEOUT_CYCLES - 40 || hit > TIMEOUT_CYCLES) begin
         bad++; $display("FAIL timeout_err_cycle got=%0d exp=%0d..%0d", hit, TIMEOUT_CYCLES - 40, TIMEOUT_CYCLES);
      end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL timeout_busy got=%b exp=0", busy); end
      send_bits(32'h7, 3);
      wait_cycles(HALF);
      key_cs_n = 1'b1;
      wait_cycles(HALF);
      total++;
      if (strobe_cnt - s0 !== 0 || err_cnt - e0 !== 1) begin
         bad++; $display("FAIL timeout_pulses strobe=%0d err=%0d exp=0/1", strobe_cnt - s0, err_cnt - e0);
      end
      s0 = strobe_cnt;
      send_frame(32'h1234, 16);
      total++;
      if (key_code !== 16'h1234 || strobe_cnt - s0 !== 1) begin
         bad++; $display("FAIL timeout_recover got=%h/%0d exp=%h/1", key_code, strobe_cnt - s0, 16'h1234);
      end
   endtask

   task automatic test_coincide;
      int s0, e0;
      s0 = strobe_cnt; e0 = err_cnt;
      key_cs_n = 1'b0;
      wait_cycles(HALF);
      send_bits(32'h0000_52E1, 15);
      key_mosi = 1'b1;
      wait_cycles(HALF);
      key_sck  = 1'b1;
      key_cs_n = 1'b1;
      wait_cycles(HALF);
      key_sck = 1'b0;
      wait_cycles(HALF);
      total++;
      if (key_code !== 16'hA5C3) begin bad++; $display("FAIL coincide_code got=%h exp=%h", key_code, 16'hA5C3); end
      total++;
      if (strobe_cnt - s0 !== 1 || err_cnt - e0 !== 0) begin
         bad++; $display("FAIL coincide_pulses got=%0d/%0d exp=1/0", strobe_cnt - s0, err_cnt - e0);
      end
   endtask

   task automatic test_reset_mid;
      int s0, e0;
      key_cs_n = 1'b0;
      wait_cycles(HALF);
      send_bits(32'h00C3, 8);
      rst_n = 1'b0;
      #1;
      total++;
      if ({key_code, key_strobe, frame_err, busy} !== 19'd0) begin
         bad++; $display("FAIL midreset_outputs got=%h/%b%b%b exp=0000/000", key_code, key_strobe, frame_err, busy);
      end
      wait_cycles(3);
      rst_n = 1'b1;
      s0 = strobe_cnt; e0 = err_cnt;
      send_bits(32'h005A, 8);
      wait_cycles(HALF);
      key_cs_n = 1'b1;
      wait_cycles(HALF);
      total++;
      if (strobe_cnt - s0 !== 0 || err_cnt - e0 !== 0 || key_code !== 16'h0000) begin
         bad++; $display("FAIL midreset_lost got=%0d/%0d/%h exp=0/0/0000", strobe_cnt - s0, err_cnt - e0, key_code);
      end
      s0 = strobe_cnt;
      send_frame(32'h5A0F, 16);
      total++;
      if (key_code !== 16'h5A0F || strobe_cnt - s0 !== 1) begin
         bad++; $display("FAIL midreset_next got=%h/%0d exp=%h/1", key_code, strobe_cnt - s0, 16'h5A0F);
      end
   endtask

   task automatic test_no_overlap;
      total++;
      if (overlap_cnt !== 0) begin bad++; $display("FAIL strobe_err_overlap got=%0d exp=0", overlap_cnt); end
   endtask

   initial begin
      total = 0; bad = 0;
      strobe_cnt = 0; err_cnt = 0; overlap_cnt = 0;
      rst_n = 1'b1; key_sck = 1'b0; key_mosi = 1'b0; key_cs_n = 1'b1;
      #2;
      test_reset;
      test_valid;
      test_length;
      test_release;
      test_timeout;
      test_coincide;
      test_reset_mid;
      test_no_overlap;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
